// File: rtl/register_file.sv
// 32 x XLEN RISC-V integer register file: two combinational read ports, one synchronous write port, x0 hardwired to zero.
// Optional macro REGFILE_BYPASS_EN adds a write-first bypass from WD3 to each read port.
module register_file #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [XLEN-1:0]   WD3,
  output logic [XLEN-1:0]   RD1,
  output logic [XLEN-1:0]   RD2
);

  localparam int NREGS = 2 ** ADDR_W;

  // x0 has no storage; the array starts at index 1
  logic [XLEN-1:0] regs_q [1:NREGS-1];
  logic [XLEN-1:0] regs_d [1:NREGS-1];

  always_comb begin
    regs_d = regs_q;
    if (WE3 && (A3 != '0)) begin
      regs_d[A3] = WD3;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // While CLR is low the array is already cleared, so reads naturally return zero
  always_comb begin
    RD1 = '0;
    if (A1 != '0) begin
      RD1 = regs_q[A1];
    end
`ifdef REGFILE_BYPASS_EN
    if (CLR && WE3 && (A3 != '0) && (A1 == A3)) begin
      RD1 = WD3;
    end
`endif
  end

  always_comb begin
    RD2 = '0;
    if (A2 != '0) begin
      RD2 = regs_q[A2];
    end
`ifdef REGFILE_BYPASS_EN
    if (CLR && WE3 && (A3 != '0) && (A2 == A3)) begin
      RD2 = WD3;
    end
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read values, a monitor compares them mid-cycle.
// Expectations follow the REGFILE_BYPASS_EN build setting.
module tb_register_file;

  logic        CLK;
  logic        CLR;
  logic        WE3;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [31:0] RD1;
  logic [31:0] RD2;

  typedef struct {
    string       name;
    bit          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  register_file #(.XLEN(32), .ADDR_W(5)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .WE3 (WE3),
    .A1  (A1),
    .A2  (A2),
    .A3  (A3),
    .WD3 (WD3),
    .RD1 (RD1),
    .RD2 (RD2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change just after a rising edge so the following falling edge sees settled outputs
  task automatic apply_stimulus(input logic clr, input logic we, input logic [4:0] a1,
                                input logic [4:0] a2, input logic [4:0] a3, input logic [31:0] wd);
    @(posedge CLK);
    #1;
    CLR = clr;
    WE3 = we;
    A1  = a1;
    A2  = a2;
    A3  = a3;
    WD3 = wd;
  endtask

  task automatic push_expect(input string name, input bit port, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic check_output(input exp_t e);
    logic [31:0] actual;
    actual = e.port ? RD2 : RD1;
    checks++;
    if (actual !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s: RD%0d got 0x%08h, expected 0x%08h", e.name, e.port ? 2 : 1, actual, e.exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check_output(e);
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    CLR = 1'b0;
    WE3 = 1'b0;
    A1  = 5'd0;
    A2  = 5'd0;
    A3  = 5'd0;
    WD3 = 32'h0;

    // Reset held: reads are zero and a write attempt is ignored
    apply_stimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    push_expect("reset_rd1", 1'b0, 32'h0);
    push_expect("reset_rd2", 1'b1, 32'h0);
    apply_stimulus(1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 32'h1111_1111);
    push_expect("reset_write_pending", 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 32'h0);
    push_expect("reset_write_ignored", 1'b1, 32'h0);

    // Release, write x5, then assert reset between edges
    apply_stimulus(1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 32'h1234_5678);
    push_expect("x5_before_edge", 1'b0, BYPASS ? 32'h1234_5678 : 32'h0);
    apply_stimulus(1'b1, 1'b0, 5'd5, 5'd0, 5'd5, 32'h0);
    push_expect("x5_after_edge", 1'b0, 32'h1234_5678);
    apply_stimulus(1'b0, 1'b0, 5'd5, 5'd0, 5'd5, 32'h0);
    push_expect("async_reset_x5", 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0);
    push_expect("x5_cleared_rd1", 1'b0, 32'h0);
    push_expect("x5_cleared_rd2", 1'b1, 32'h0);

    // Write disabled: two edges with WE3=0 leave x1 at zero
    apply_stimulus(1'b1, 1'b0, 5'd1, 5'd0, 5'd1, 32'h0ABC_DEF0);
    push_expect("we_off_before", 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 5'd1, 5'd0, 5'd1, 32'h0ABC_DEF0);
    apply_stimulus(1'b1, 1'b0, 5'd1, 5'd0, 5'd1, 32'h0ABC_DEF0);
    push_expect("we_off_x1", 1'b0, 32'h0);

    // Writes to x0 are dropped and never bypass
    apply_stimulus(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0ABC_DEF0);
    push_expect("x0_write_same_cycle", 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    push_expect("x0_after_write_rd1", 1'b0, 32'h0);
    push_expect("x0_after_write_rd2", 1'b1, 32'h0);

    // Write x1, then x4 while keeping x1 visible on RD1
    apply_stimulus(1'b1, 1'b1, 5'd1, 5'd0, 5'd1, 32'h0ABC_DEF0);
    push_expect("x1_before_edge", 1'b0, BYPASS ? 32'h0ABC_DEF0 : 32'h0);
    apply_stimulus(1'b1, 1'b1, 5'd1, 5'd4, 5'd4, 32'hFFFF_FFFF);
    push_expect("x1_after_edge", 1'b0, 32'h0ABC_DEF0);
    push_expect("x4_before_edge", 1'b1, BYPASS ? 32'hFFFF_FFFF : 32'h0);
    apply_stimulus(1'b1, 1'b0, 5'd1, 5'd4, 5'd4, 32'h5555_5555);
    push_expect("x1_held", 1'b0, 32'h0ABC_DEF0);
    push_expect("x4_after_edge", 1'b1, 32'hFFFF_FFFF);

    // WE3=0 with new data on WD3 must not disturb x4; both ports read the same register
    apply_stimulus(1'b1, 1'b0, 5'd4, 5'd4, 5'd4, 32'h5555_5555);
    push_expect("x4_hold_rd1", 1'b0, 32'hFFFF_FFFF);
    push_expect("x4_hold_rd2", 1'b1, 32'hFFFF_FFFF);

    // Same-cycle read of the write target x7 on RD1 while RD2 reads x1
    apply_stimulus(1'b1, 1'b1, 5'd7, 5'd1, 5'd7, 32'hDEAD_BEEF);
    push_expect("x7_before_edge", 1'b0, BYPASS ? 32'hDEAD_BEEF : 32'h0);
    push_expect("x1_during_x7_write", 1'b1, 32'h0ABC_DEF0);
    apply_stimulus(1'b1, 1'b0, 5'd7, 5'd4, 5'd7, 32'h0);
    push_expect("x7_after_edge", 1'b0, 32'hDEAD_BEEF);
    push_expect("x4_after_x7_write", 1'b1, 32'hFFFF_FFFF);

    // Top address x31 and a final sweep of the written registers
    apply_stimulus(1'b1, 1'b1, 5'd1, 5'd31, 5'd31, 32'hA5A5_A5A5);
    push_expect("x31_before_edge", 1'b1, BYPASS ? 32'hA5A5_A5A5 : 32'h0);
    apply_stimulus(1'b1, 1'b0, 5'd1, 5'd31, 5'd0, 32'h0);
    push_expect("x31_x1_rd1", 1'b0, 32'h0ABC_DEF0);
    push_expect("x31_after_edge", 1'b1, 32'hA5A5_A5A5);
    apply_stimulus(1'b1, 1'b0, 5'd7, 5'd5, 5'd0, 32'h0);
    push_expect("x7_final", 1'b0, 32'hDEAD_BEEF);
    push_expect("x5_final", 1'b1, 32'h0);

    @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
